// File: rtl/avalon_sdram_responder.sv
// Stand-in for the SDRAM controller's Avalon-MM s1 port: an on-chip word store
// that reproduces the controller's wait states, pipelined read latency and refresh stalls.
module avalon_sdram_responder #(
   parameter int MEM_AW         = 10,
   parameter int WAIT_CYCLES    = 2,
   parameter int READ_LATENCY   = 3,
   parameter int REFRESH_PERIOD = 64,
   parameter int REFRESH_CYCLES = 4
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic [22:0] s_address,
   input  logic [3:0]  s_byteenable_n,
   input  logic        s_chipselect,
   input  logic [31:0] s_writedata,
   input  logic        s_read_n,
   input  logic        s_write_n,
   output logic [31:0] s_readdata,
   output logic        s_readdatavalid,
   output logic        s_waitrequest,
   output logic        o_proto_err
);
   localparam int CW = 16;
   localparam logic [CW-1:0] WAIT_LOAD   = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;
   localparam logic [CW-1:0] RC_LOAD     = (REFRESH_CYCLES > 0) ? CW'(REFRESH_CYCLES - 1) : '0;
   localparam logic [CW-1:0] RC_LOAD_CMD = (REFRESH_CYCLES > 1) ? CW'(REFRESH_CYCLES - 2) : '0;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_REFRESH} state_t;

   state_t            state_reg, state_next;
   logic [CW-1:0]     wcnt_reg, wcnt_next;
   logic [CW-1:0]     rcnt_reg, rcnt_next;
   logic              ref_pend_reg;
   logic              ref_take;
   logic              ref_wrap;
   logic              wait_req;
   logic              cmd, accepted, wr_accept, rd_accept, both_req;
   logic              proto_err_reg;
   logic [MEM_AW-1:0] addr;
   logic [31:0]       rd_word;
   logic [READ_LATENCY-1:0] vld_reg;

   assign cmd       = s_chipselect & (~s_read_n | ~s_write_n);
   assign both_req  = ~s_read_n & ~s_write_n;
   assign accepted  = cmd & ~s_waitrequest;
   assign wr_accept = accepted & ~s_write_n;
   assign rd_accept = accepted & s_write_n;
   assign addr      = s_address[MEM_AW-1:0];

   generate
      if (MEM_AW < 23) begin : g_alias
         logic unused_addr_hi;
         assign unused_addr_hi = ^s_address[22:MEM_AW];
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_reg <= ST_IDLE;
         wcnt_reg  <= '0;
         rcnt_reg  <= '0;
      end else begin
         state_reg <= state_next;
         wcnt_reg  <= wcnt_next;
         rcnt_reg  <= rcnt_next;
      end
   end

   // When a command is already waiting, the IDLE cycle that spots the refresh is
   // itself the first stall cycle, so the initiator sees exactly REFRESH_CYCLES.
   always_comb begin
      state_next = state_reg;
      wcnt_next  = wcnt_reg;
      rcnt_next  = rcnt_reg;
      ref_take   = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (ref_pend_reg) begin
               ref_take = 1'b1;
               if (!(cmd && REFRESH_CYCLES == 1)) begin
                  state_next = ST_REFRESH;
                  rcnt_next  = cmd ? RC_LOAD_CMD : RC_LOAD;
               end
            end else if (cmd && WAIT_CYCLES > 0) begin
               state_next = ST_WAIT;
               wcnt_next  = WAIT_LOAD;
            end
         end
         ST_WAIT: begin
            if (!cmd || wcnt_reg == '0) state_next = ST_IDLE;
            else wcnt_next = wcnt_reg - CW'(1);
         end
         ST_REFRESH: begin
            if (rcnt_reg == '0) state_next = ST_IDLE;
            else rcnt_next = rcnt_reg - CW'(1);
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      wait_req = 1'b1;
      case (state_reg)
         ST_IDLE:    wait_req = cmd & (ref_pend_reg | (WAIT_CYCLES > 0));
         ST_WAIT:    wait_req = (wcnt_reg != '0);
         ST_REFRESH: wait_req = 1'b1;
         default:    wait_req = 1'b1;
      endcase
   end

   assign s_waitrequest = i_rst | wait_req;

   generate
      if (REFRESH_PERIOD > 0) begin : g_refresh
         logic [31:0] ref_cnt_reg;
         assign ref_wrap = (ref_cnt_reg == 32'(REFRESH_PERIOD - 1));
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) ref_cnt_reg <= '0;
            else ref_cnt_reg <= ref_wrap ? '0 : ref_cnt_reg + 32'd1;
         end
      end else begin : g_no_refresh
         assign ref_wrap = 1'b0;
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) ref_pend_reg <= 1'b0;
      else if (ref_wrap) ref_pend_reg <= 1'b1;
      else if (ref_take) ref_pend_reg <= 1'b0;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) proto_err_reg <= 1'b0;
      else if (wr_accept && both_req) proto_err_reg <= 1'b1;
   end
   assign o_proto_err = proto_err_reg;

   // One byte-wide store per lane keeps byte enables as plain RAM write enables.
   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem [2**MEM_AW];
         logic [7:0] lane_q;
         always_ff @(posedge i_clk) begin
            if (wr_accept && !s_byteenable_n[gi]) mem[addr] <= s_writedata[8*gi +: 8];
         end
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) lane_q <= '0;
            else if (rd_accept) lane_q <= mem[addr];
         end
         assign rd_word[8*gi +: 8] = lane_q;
      end
   endgenerate

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         vld_reg <= '0;
      end else begin
         vld_reg[0] <= rd_accept;
         for (int k = 1; k < READ_LATENCY; k++) vld_reg[k] <= vld_reg[k-1];
      end
   end
   assign s_readdatavalid = vld_reg[READ_LATENCY-1];

   // Data stages load only behind a valid, so the output holds its last word.
   generate
      if (READ_LATENCY == 1) begin : g_lat1
         assign s_readdata = rd_word;
      end else begin : g_dpipe
         logic [31:0] dpipe_reg [READ_LATENCY-1];
         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               for (int k = 0; k < READ_LATENCY - 1; k++) dpipe_reg[k] <= '0;
            end else begin
               if (vld_reg[0]) dpipe_reg[0] <= rd_word;
               for (int k = 1; k < READ_LATENCY - 1; k++)
                  if (vld_reg[k]) dpipe_reg[k] <= dpipe_reg[k-1];
            end
         end
         assign s_readdata = dpipe_reg[READ_LATENCY-2];
      end
   endgenerate
endmodule

// File: doc/avalon_sdram_responder.md
Name: avalon_sdram_responder

Overview:
- Avalon-MM slave that answers the same s1 interface the SDRAM controller presents to the bus initiator.
- Backed by an on-chip word array; models the controller's timing: programmable wait states, fixed pipelined read latency, periodic refresh stalls.
- Stands in for the SDRAM controller in block-level simulation and FPGA bring-up, so initiator-side logic can be closed without external DRAM.

Parameters:
- MEM_AW, 10, word-address bits actually stored; depth 2^MEM_AW 32-bit words.
- WAIT_CYCLES, 2, cycles waitrequest is held high before a command is accepted (0 = accept on first cycle).
- READ_LATENCY, 3, cycles from read-acceptance edge to readdatavalid (legal range 1..8).
- REFRESH_PERIOD, 64, cycles between refresh requests (0 = refresh disabled).
- REFRESH_CYCLES, 4, cycles waitrequest is forced high per refresh.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- s_address  in  23  word address; bits [MEM_AW-1:0] used, upper bits ignored (aliasing)
- s_byteenable_n  in  4  active-low byte lanes for writes; ignored on reads
- s_chipselect  in  1  command qualifier
- s_writedata  in  32  write data
- s_read_n  in  1  active-low read request
- s_write_n  in  1  active-low write request
- s_readdata  out  32  read data, valid only with s_readdatavalid
- s_readdatavalid  out  1  one-cycle pulse per accepted read
- s_waitrequest  out  1  command stall
- o_proto_err  out  1  sticky: read and write requested together

Behaviour:
- Reset: asynchronous, active-high on i_rst, clock i_clk. During and after reset:
  - s_waitrequest=1 while i_rst high, then 0 once i_rst releases.
  - s_readdatavalid=0, s_readdata=0, o_proto_err=0.
  - Read pipeline flushed; counters cleared; FSM=IDLE.
  - Memory contents not reset.
- cmd = s_chipselect & (!s_read_n | !s_write_n).
- Accepted = cmd & !s_waitrequest at a rising edge.
- FSM states: IDLE, WAIT, REFRESH.
- IDLE:
  - If refresh_pending and no cmd: go to REFRESH.
  - If cmd and WAIT_CYCLES=0: s_waitrequest=0, command accepted this cycle, stay IDLE.
  - If cmd and WAIT_CYCLES>0: s_waitrequest=1, load wcnt=WAIT_CYCLES-1, go to WAIT.
  - No cmd: s_waitrequest=0.
- WAIT:
  - s_waitrequest=(wcnt!=0); wcnt decrements each cycle.
  - At wcnt=0, command accepted, return to IDLE.
  - If cmd drops while in WAIT: return to IDLE without access.
  - Next command always incurs full wait again.
- REFRESH:
  - s_waitrequest=1 for exactly REFRESH_CYCLES cycles, then IDLE.
  - refresh_pending cleared on entry.
- Refresh counter:
  - Free-running modulo REFRESH_PERIOD; sets refresh_pending on wrap.
  - Pending is serviced only from IDLE, so an in-progress WAIT always completes first.
  - Pending has priority over a new cmd arriving in IDLE.
- Accepted write:
  - Memory written at the acceptance edge, byte lane k only where s_byteenable_n[k]=0.
  - byteenable_n=4'hF is a legal no-op.
- Accepted read:
  - Memory word at address captured at the acceptance edge into a READ_LATENCY-deep valid/data shift pipeline.
  - s_readdatavalid=1 and s_readdata=word exactly READ_LATENCY cycles after acceptance.
  - Pipeline runs independently of FSM (drains through WAIT/REFRESH); back-to-back accepted reads give back-to-back valids, in order.
  - s_readdata holds its last value when not valid.
- Ordering: a read accepted after a write to the same address returns the new data. Writes take effect at their acceptance edge; reads sample after that edge.
- Both s_read_n and s_write_n low with s_chipselect:
  - Treated as a write.
  - o_proto_err set at acceptance, stays set until reset.
- s_chipselect=0: requests ignored, s_waitrequest=0 in IDLE.
- Reset mid-operation: pending read valids discarded; no spurious readdatavalid after release.

Test Plan:
- Reset release, REFRESH_PERIOD=0, WAIT_CYCLES=2: write 0xDEADBEEF to addr 5 with byteenable_n=0 -> waitrequest high exactly 2 cycles, then low one cycle (accept); single read of addr 5 -> readdatavalid pulses 3 cycles after acceptance with readdata=0xDEADBEEF.
- Partial write: after the above, write 0x11223344 to addr 5 with byteenable_n=4'b1010 -> read returns 0xDE22BE44.
- WAIT_CYCLES=0, 4 back-to-back reads of addr 0..3 preloaded with 0xA0..0xA3 -> waitrequest never high; 4 consecutive valid pulses starting 3 cycles after first accept, data 0xA0,0xA1,0xA2,0xA3.
- REFRESH_PERIOD=16, REFRESH_CYCLES=4, initiator holds read every cycle -> every 16 cycles waitrequest high for 4 cycles with no acceptance; in-flight read valids still emerge on schedule.
- Aliasing and protocol error: write 0x55 to addr 0x400 (MEM_AW=10) with read_n=write_n=0 -> o_proto_err=1; read addr 0 returns 0x55.
- Reset asserted 1 cycle after a read acceptance -> readdatavalid never pulses; waitrequest=1 during reset, 0 after release; o_proto_err cleared.
